calc_entry_ctrl: RTL and testbench

//  Keypad-entry controller sitting directly upstream of the calculator ALU.

---
 rtl/calc_entry_ctrl_if.sv | 26 ++
 rtl/calc_entry_ctrl.sv | 159 +++++++++++++++
 tb/tb_calc_entry_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/calc_entry_ctrl_if.sv
// Bus between the keypad-entry controller, the key decoder and the calculator ALU.
// Handshake: key_valid is a one-cycle strobe with no ready; key_code is sampled only while key_valid is high.
interface calc_entry_ctrl_if #(
    parameter int DATA_W = 14
);
    logic              key_valid;
    logic [3:0]        key_code;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] operator1;
    logic [DATA_W-1:0] operator2;
    logic [1:0]        operationVal;
    logic              opEnable;
    logic              eqEnable;
    logic [DATA_W-1:0] display_val;
    logic              busy;

    modport slave (
        input  key_valid, key_code, alu_result,
        output operator1, operator2, operationVal, opEnable, eqEnable, display_val, busy
    );

    modport master (
        output key_valid, key_code, alu_result,
        input  operator1, operator2, operationVal, opEnable, eqEnable, display_val, busy
    );
endinterface

// File: rtl/calc_entry_ctrl.sv
// Keypad-entry controller: builds two decimal operands and an op code, strobes the ALU,
// captures its result one cycle later and supports chaining from the last result.
module calc_entry_ctrl #(
    parameter int DATA_W     = 14,
    parameter int MAX_DIGITS = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    calc_entry_ctrl_if.slave  bus,
    output logic [2:0]        state_o
);
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    typedef enum logic [2:0] {
        S_OP1    = 3'd0,
        S_OPSEL  = 3'd1,
        S_OP2    = 3'd2,
        S_EXEC   = 3'd3,
        S_WAIT   = 3'd4,
        S_RESULT = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] op1_q, op1_d, op2_q, op2_d, res_q, res_d, disp_q, disp_d;
    logic [1:0]        opv_q, opv_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              op_en_q, op_en_d, eq_en_q, eq_en_d, busy_q, busy_d;

    logic              is_digit, is_op, is_eq, is_clr, can_append;
    logic [DATA_W-1:0] digit;
    logic [1:0]        key_op;

    // Wide intermediate so v*10+d cannot wrap before truncation; the digit cap keeps v <= 9999.
    function automatic logic [DATA_W-1:0] append(input logic [DATA_W-1:0] v, input logic [3:0] d);
        logic [DATA_W+3:0] w;
        w = {4'b0, v} * (DATA_W+4)'(10) + (DATA_W+4)'(d);
        return w[DATA_W-1:0];
    endfunction

    always_comb begin
        is_digit   = bus.key_valid && (bus.key_code <= 4'd9);
        is_op      = bus.key_valid && (bus.key_code >= 4'd10) && (bus.key_code <= 4'd13);
        is_eq      = bus.key_valid && (bus.key_code == 4'd14);
        is_clr     = bus.key_valid && (bus.key_code == 4'd15);
        can_append = cnt_q < CNT_W'(MAX_DIGITS);
        digit      = DATA_W'(bus.key_code);
        key_op     = 2'(bus.key_code - 4'd10);

        state_d = state_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        res_d   = res_q;
        opv_d   = opv_q;
        cnt_d   = cnt_q;

        if (is_clr) begin
            state_d = S_OP1;
            op1_d   = '0;
            op2_d   = '0;
            res_d   = '0;
            opv_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_OP1: begin
                    if (is_digit && can_append) begin
                        op1_d = append(op1_q, bus.key_code);
                        cnt_d = cnt_q + 1'b1;
                    end else if (is_op) begin
                        opv_d   = key_op;
                        state_d = S_OPSEL;
                    end
                end
                S_OPSEL: begin
                    if (is_op) begin
                        opv_d = key_op;
                    end else if (is_digit) begin
                        op2_d   = digit;
                        cnt_d   = CNT_W'(1);
                        state_d = S_OP2;
                    end
                end
                S_OP2: begin
                    if (is_digit && can_append) begin
                        op2_d = append(op2_q, bus.key_code);
                        cnt_d = cnt_q + 1'b1;
                    end else if (is_eq) begin
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: state_d = S_WAIT;
                S_WAIT: begin
                    res_d   = bus.alu_result;
                    state_d = S_RESULT;
                end
                S_RESULT: begin
                    if (is_op) begin
                        op1_d   = res_q;
                        op2_d   = '0;
                        opv_d   = key_op;
                        state_d = S_OPSEL;
                    end else if (is_digit) begin
                        op1_d   = digit;
                        op2_d   = '0;
                        cnt_d   = CNT_W'(1);
                        state_d = S_OP1;
                    end
                end
                default: state_d = S_OP1;
            endcase
        end

        // Outputs are computed from the next state so the registered strobes line up with the state.
        op_en_d = (state_d == S_EXEC);
        eq_en_d = (state_d == S_WAIT);
        busy_d  = op_en_d || eq_en_d;
        case (state_d)
            S_OP1, S_OPSEL:        disp_d = op1_d;
            S_OP2, S_EXEC, S_WAIT: disp_d = op2_d;
            S_RESULT:              disp_d = res_d;
            default:               disp_d = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_OP1;
            op1_q   <= '0;
            op2_q   <= '0;
            res_q   <= '0;
            opv_q   <= '0;
            cnt_q   <= '0;
            op_en_q <= 1'b0;
            eq_en_q <= 1'b0;
            busy_q  <= 1'b0;
            disp_q  <= '0;
        end else begin
            state_q <= state_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            res_q   <= res_d;
            opv_q   <= opv_d;
            cnt_q   <= cnt_d;
            op_en_q <= op_en_d;
            eq_en_q <= eq_en_d;
            busy_q  <= busy_d;
            disp_q  <= disp_d;
        end
    end

    assign bus.operator1    = op1_q;
    assign bus.operator2    = op2_q;
    assign bus.operationVal = opv_q;
    assign bus.opEnable     = op_en_q;
    assign bus.eqEnable     = eq_en_q;
    assign bus.busy         = busy_q;
    assign bus.display_val  = disp_q;
    assign state_o          = state_q;
endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Bench for calc_entry_ctrl: key driver, behavioural ALU, scoreboard of expected ALU transactions.
module tb_calc_entry_ctrl;
    localparam int W = 14;
    localparam logic [2:0] ST_OP1 = 3'd0, ST_OPSEL = 3'd1, ST_RESULT = 3'd5;
    localparam logic [3:0] K_ADD = 4'd10, K_SUB = 4'd11, K_MUL = 4'd12, K_DIV = 4'd13,
                           K_EQ = 4'd14, K_CLR = 4'd15;

    logic       clk;
    logic       rst_n;
    logic [2:0] state;
    int         total = 0;
    int         bad = 0;
    int         op_en_cnt = 0;

    // Expected ALU transaction: {operator1, operator2, operationVal, result}.
    logic [3*W+1:0] exp_q[$];
    logic [W-1:0]   res_q[$];

    calc_entry_ctrl_if #(.DATA_W(W)) bus ();

    calc_entry_ctrl #(.DATA_W(W), .MAX_DIGITS(4)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus),
        .state_o(state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural ALU with one cycle of latency.
    always @(posedge clk) begin
        if (bus.opEnable) begin
            case (bus.operationVal)
                2'd0: bus.alu_result <= bus.operator1 + bus.operator2;
                2'd1: bus.alu_result <= bus.operator1 - bus.operator2;
                2'd2: bus.alu_result <= W'(bus.operator1 * bus.operator2);
                default: bus.alu_result <= (bus.operator2 == '0) ? W'(9999) : bus.operator1 / bus.operator2;
            endcase
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic press(input logic [3:0] code);
        bus.key_valid = 1'b1;
        bus.key_code  = code;
        @(negedge clk);
        bus.key_valid = 1'b0;
        bus.key_code  = 4'd0;
    endtask

    task automatic push_exp(input int a, input int b, input int op, input int res);
        exp_q.push_back({W'(a), W'(b), 2'(op), W'(res)});
    endtask

    task automatic wait_result();
        for (int i = 0; i < 10 && state != ST_RESULT; i++) @(negedge clk);
        check("state_result", state, ST_RESULT);
        if (res_q.size() == 0) check("res_q_nonempty", 0, 1);
        else check("display_result", bus.display_val, res_q.pop_front());
    endtask

    // Scoreboard: every opEnable strobe consumes one expected transaction.
    always @(negedge clk) begin
        if (rst_n && (bus.opEnable || bus.eqEnable)) begin
            check("op_eq_exclusive", bus.opEnable & bus.eqEnable, 0);
            check("busy_when_strobe", bus.busy, 1);
        end
        if (rst_n && bus.opEnable) begin
            op_en_cnt++;
            if (exp_q.size() == 0) begin
                check("exp_q_nonempty", 0, 1);
            end else begin
                logic [3*W+1:0] e;
                e = exp_q.pop_front();
                check("operator1", bus.operator1, e[3*W+1:2*W+2]);
                check("operator2", bus.operator2, e[2*W+1:W+2]);
                check("operationVal", bus.operationVal, e[W+1:W]);
                res_q.push_back(e[W-1:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.key_valid  = 1'b0;
        bus.key_code   = 4'd0;
        bus.alu_result = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("reset_outputs", {bus.operator1, bus.operator2, bus.operationVal, bus.opEnable,
                                bus.eqEnable, bus.display_val, bus.busy}, 0);
        check("reset_state", state, ST_OP1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset in the middle of entry.
        press(4'd4);
        press(4'd2);
        check("entry_42", bus.display_val, 42);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {bus.operator1, bus.operator2, bus.operationVal, bus.opEnable,
                                      bus.eqEnable, bus.display_val, bus.busy}, 0);
        check("async_reset_state", state, ST_OP1);
        @(negedge clk);
        rst_n = 1'b1;
        press(4'd7);
        check("after_reset_7", bus.display_val, 7);

        // Fifth digit is ignored.
        press(K_CLR);
        check("clear_display", bus.display_val, 0);
        for (int i = 1; i <= 5; i++) press(4'(i));
        check("digit_cap_op1", bus.operator1, 1234);
        check("digit_cap_disp", bus.display_val, 1234);

        // Operator replacement and equal ignored in S_OPSEL.
        press(K_CLR);
        press(4'd7);
        press(K_ADD);
        press(K_SUB);
        press(K_EQ);
        check("eq_ignored_opsel", state, ST_OPSEL);
        press(K_DIV);
        press(4'd2);
        push_exp(7, 2, 3, 3);
        press(K_EQ);
        wait_result();

        // Basic addition.
        press(K_CLR);
        press(4'd1);
        press(4'd2);
        press(K_ADD);
        press(4'd3);
        press(4'd4);
        check("op2_display", bus.display_val, 34);
        push_exp(12, 34, 0, 46);
        press(K_EQ);
        @(negedge clk);
        check("eq_enable_after_op", bus.eqEnable, 1);
        check("op_enable_single", bus.opEnable, 0);
        wait_result();

        // Chaining from the last result, then a fresh digit.
        press(K_MUL);
        check("chain_op1", bus.operator1, 46);
        press(4'd2);
        push_exp(46, 2, 2, 92);
        press(K_EQ);
        wait_result();
        press(4'd5);
        check("digit_after_result_op1", bus.operator1, 5);
        check("digit_after_result_state", state, ST_OP1);
        check("digit_after_result_op2", bus.operator2, 0);

        // Clear on the S_WAIT cycle discards the in-flight result.
        press(K_CLR);
        press(4'd3);
        press(K_ADD);
        press(4'd4);
        push_exp(3, 4, 0, 7);
        press(K_EQ);
        @(negedge clk);
        check("wait_eq_enable", bus.eqEnable, 1);
        press(K_CLR);
        check("clear_wait_state", state, ST_OP1);
        check("clear_wait_outputs", {bus.operator1, bus.operator2, bus.operationVal, bus.opEnable,
                                     bus.eqEnable, bus.display_val, bus.busy}, 0);
        if (res_q.size() != 0) void'(res_q.pop_front());
        press(4'd9);
        check("key_after_clear", bus.display_val, 9);
        press(K_ADD);
        press(4'd1);
        push_exp(9, 1, 0, 10);
        press(K_EQ);
        wait_result();

        repeat (3) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        check("op_enable_count", op_en_cnt, 5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
